// File: rtl/horizontal_tf_gen.sv
// horizontal_tf_gen: burst-windowed twiddle-factor generator fed from a runtime-writable table.
// Build option HTF_HOLD_EN: outside the burst window Q keeps its last factor instead of going to 0.
module horizontal_tf_gen #(
    parameter int P_WIDTH   = 64,
    parameter int S_WIDTH   = 4,
    parameter int SC_WIDTH  = 3,
    parameter int DEPTH     = 64,
    parameter int PERIOD    = 16,
    parameter int BURST     = 4,
    parameter int ADV_PHASE = 7,
    parameter int IDX_INIT  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [S_WIDTH-1:0]       state,
    input  logic [SC_WIDTH-1:0]      stage_counter,
    input  logic [SC_WIDTH-1:0]      active_stage,
    input  logic                     CEN,
    input  logic                     restart,
    input  logic                     tbl_we,
    input  logic [$clog2(DEPTH)-1:0] tbl_addr,
    input  logic [P_WIDTH-1:0]       tbl_wdata,
    output logic [P_WIDTH-1:0]       Q,
    output logic                     Q_valid,
    output logic [$clog2(DEPTH)-1:0] idx
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(PERIOD);
    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
    localparam logic [CW-1:0] ADV_AT   = CW'(ADV_PHASE);
    localparam logic [CW:0]   BURST_W  = (CW + 1)'(BURST);
    localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] IDX_RST  = AW'(IDX_INIT);

    generate
        if (BURST < 1 || BURST > PERIOD || ADV_PHASE >= PERIOD || PERIOD < 2 ||
            IDX_INIT >= DEPTH || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
            $error("horizontal_tf_gen: illegal parameter combination");
        end
    endgenerate

    logic unused_state;
    assign unused_state = ^state;

    logic [P_WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [AW-1:0]      idx_q, idx_d;
    logic [P_WIDTH-1:0] q_q, q_d;
    logic               qv_q, qv_d;
    logic               adv, in_burst;

    // Table has no reset: contents must survive rst_n and restart.
    always_ff @(posedge clk) begin
        if (tbl_we) mem[tbl_addr] <= tbl_wdata;
    end

    assign adv      = ~CEN && (stage_counter == active_stage);
    assign in_burst = {1'b0, cnt_q} < BURST_W;

    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        q_d   = q_q;
        qv_d  = qv_q;
        if (restart) begin
            cnt_d = '0;
            idx_d = IDX_RST;
            q_d   = '0;
            qv_d  = 1'b0;
        end else begin
            // Output follows pre-update cnt/idx, even when the stage does not match.
            if (!CEN) begin
                qv_d = in_burst;
                if (in_burst) begin
                    q_d = mem[idx_q];
                end else begin
`ifdef HTF_HOLD_EN
                    q_d = q_q;
`else
                    q_d = '0;
`endif
                end
            end
            if (adv) begin
                cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
                if (cnt_q == ADV_AT)
                    idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= IDX_RST;
            q_q   <= '0;
            qv_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            q_q   <= q_d;
            qv_q  <= qv_d;
        end
    end

    assign Q       = q_q;
    assign Q_valid = qv_q;
    assign idx     = idx_q;
endmodule

// File: tb/tb_horizontal_tf_gen.sv
// Self-checking bench for horizontal_tf_gen: directed test-plan sequences plus random traffic vs a frame-level model.
module tb_horizontal_tf_gen;
    localparam int DEPTH = 8, PERIOD = 16, BURST = 4, ADV_PHASE = 7, IDX_INIT = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  state;
    logic [2:0]  stage_counter, active_stage;
    logic        CEN, restart, tbl_we;
    logic [2:0]  tbl_addr;
    logic [63:0] tbl_wdata;
    logic [63:0] Q;
    logic        Q_valid;
    logic [2:0]  idx;

    int n_cmp = 0, n_err = 0;

    // Reference model: frame position, table index, output register, table image.
    int          m_cnt, m_idx;
    logic [63:0] m_q;
    logic        m_v;
    logic [63:0] m_tbl [DEPTH];

    horizontal_tf_gen #(.P_WIDTH(64), .S_WIDTH(4), .SC_WIDTH(3), .DEPTH(DEPTH),
                        .PERIOD(PERIOD), .BURST(BURST), .ADV_PHASE(ADV_PHASE),
                        .IDX_INIT(IDX_INIT)) dut (
        .clk(clk), .rst_n(rst_n), .state(state), .stage_counter(stage_counter),
        .active_stage(active_stage), .CEN(CEN), .restart(restart), .tbl_we(tbl_we),
        .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata), .Q(Q), .Q_valid(Q_valid), .idx(idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] gap_q(input logic [63:0] last);
`ifdef HTF_HOLD_EN
        return last;
`else
        return 64'(last & 64'd0);
`endif
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_idx = IDX_INIT; m_q = '0; m_v = 1'b0;
    endtask

    task automatic model_step();
        if (restart) begin
            model_reset();
        end else if (!CEN) begin
            m_v = (m_cnt < BURST);
            m_q = m_v ? m_tbl[m_idx] : gap_q(m_q);
            if (stage_counter == active_stage) begin
                if (m_cnt == ADV_PHASE) m_idx = (m_idx + 1) % DEPTH;
                m_cnt = (m_cnt + 1) % PERIOD;
            end
        end
        if (tbl_we) m_tbl[tbl_addr] = tbl_wdata;
    endtask

    task automatic cyc(input logic cen, input logic [2:0] sc, input logic rs,
                       input logic we, input logic [2:0] a, input logic [63:0] d);
        CEN = cen; stage_counter = sc; restart = rs;
        tbl_we = we; tbl_addr = a; tbl_wdata = d; state = 4'($urandom);
        model_step();
        @(posedge clk); #1;
        chk("Q", Q, m_q);
        chk("Q_valid", 64'(Q_valid), 64'(m_v));
        chk("idx", 64'(idx), 64'(m_idx));
    endtask

    task automatic run(input int n, input logic cen, input logic [2:0] sc);
        repeat (n) cyc(cen, sc, 1'b0, 1'b0, 3'd0, 64'd0);
    endtask

    initial begin
        state = '0; stage_counter = '0; active_stage = '0;
        CEN = 1'b1; restart = 1'b0; tbl_we = 1'b0; tbl_addr = '0; tbl_wdata = '0;
        model_reset();
        #12;
        chk("rst_Q", Q, 64'd0);
        chk("rst_valid", 64'(Q_valid), 64'd0);
        chk("rst_idx", 64'(idx), 64'(IDX_INIT));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 3'd0, 1'b0, 1'b1, 3'(i), 64'(100 + i));

        // Frame 1: four valid cycles of table[1], twelve gap cycles, then table[2].
        for (int i = 0; i < BURST; i++) begin
            run(1, 1'b0, 3'd0);
            chk("t1_burst", Q, 64'd101);
            chk("t1_bvalid", 64'(Q_valid), 64'd1);
        end
        for (int i = 0; i < PERIOD - BURST; i++) begin
            run(1, 1'b0, 3'd0);
            chk("t1_gap", Q, gap_q(64'd101));
            chk("t1_gvalid", 64'(Q_valid), 64'd0);
        end
        run(1, 1'b0, 3'd0);
        chk("t1_frame2", Q, 64'd102);

        // Stage mismatch freezes cnt/idx; resuming continues the sequence.
        run(20, 1'b0, 3'd2);
        chk("t2_idx_frozen", 64'(idx), 64'd2);
        chk("t2_q_frozen", Q, 64'd102);
        run(PERIOD - 1, 1'b0, 3'd0);
        chk("t2_idx_resume", 64'(idx), 64'd3);

        // CEN stall two cycles into a burst.
        run(2, 1'b0, 3'd0);
        run(5, 1'b1, 3'd0);
        chk("t4_hold_q", Q, 64'd103);
        chk("t4_hold_v", 64'(Q_valid), 64'd1);
        run(2, 1'b0, 3'd0);
        chk("t4_tail_v", 64'(Q_valid), 64'd1);
        run(1, 1'b0, 3'd0);
        chk("t4_end_v", 64'(Q_valid), 64'd0);
        run(PERIOD - BURST - 1, 1'b0, 3'd0);

        // Restart then 7 full frames: index walks 1..7 and wraps to 0.
        cyc(1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 64'd0);
        chk("t3_restart_idx", 64'(idx), 64'd1);
        run(7 * PERIOD, 1'b0, 3'd0);
        chk("t3_wrap_idx", 64'(idx), 64'd0);
        run(1, 1'b0, 3'd0);
        chk("t3_wrap_q", Q, 64'd100);
        run(PERIOD - 1, 1'b0, 3'd0);

        // Restart exactly at the advance phase wins over the advance.
        run(ADV_PHASE, 1'b0, 3'd0);
        cyc(1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 64'd0);
        chk("t5_idx", 64'(idx), 64'd1);
        chk("t5_q", Q, 64'd0);
        chk("t5_v", 64'(Q_valid), 64'd0);
        run(1, 1'b0, 3'd0);
        chk("t5_next", Q, 64'd101);

        // Async reset mid-burst clears outputs before any clock edge.
        run(1, 1'b0, 3'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_q", Q, 64'd0);
        chk("t6_v", 64'(Q_valid), 64'd0);
        chk("t6_idx", 64'(idx), 64'd1);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        run(1, 1'b0, 3'd0);
        chk("t6_after", Q, 64'd101);

        // Random traffic: stalls, stage changes, restarts and table writes.
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom % 8) == 0, (($urandom % 4) == 0) ? 3'd1 : 3'd0,
                ($urandom % 64) == 0, ($urandom % 8) == 0,
                3'($urandom), {$urandom, $urandom});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
